ps4_requester: RTL and testbench
================================

PS4_REQUESTER -- requirements
Module: ps4_requester

Interface
REQ-001 SHALL have parameter: CNT_W, 3, width of each per-channel pending counter (max 2^CNT_W-1 pending).
REQ-002 SHALL have parameter: STARVE_LIM, 15, wait-cycle threshold for the starvation watchdog.
REQ-003 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: push  input  4  per-channel new-work strobe, one unit per cycle per channel.
REQ-006 SHALL have port: enable  input  1  global arbitration enable request.
REQ-007 SHALL have port: gnt  input  4  grant vector returned by the 4-way priority selector.
REQ-008 SHALL have port: req  output  4  request vector to the selector; req[i] = (pend[i] != 0).
REQ-009 SHALL have port: en  output  1  registered copy of enable driven to the selector.
REQ-010 SHALL have port: pend  output  4*CNT_W  concatenated pending counters, channel 3 in the MSBs.
REQ-011 SHALL have port: ovf  output  4  per-channel sticky overflow flag.
REQ-012 SHALL have port: gnt_err  output  1  sticky illegal-grant flag.
REQ-013 SHALL have port: gnt_cnt  output  16  total accepted grants, wraps modulo 2^16.
REQ-014 SHALL have port: state  output  2  top FSM state encoding.
REQ-015 SHALL have port: starve  output  4  per-channel sticky starvation flag.

Function
REQ-016 en SHALL follow enable with exactly one cycle of latency.
REQ-017 A grant on channel i SHALL be legal only when: gnt is one-hot, req[i]=1 and en=1 in the same cycle.
REQ-018 On a legal grant, pend[i] SHALL decrement and gnt_cnt SHALL increment at the next edge.
REQ-019 push[i] with no legal grant on channel i SHALL increment pend[i].
REQ-020 push[i] together with a legal grant on channel i SHALL leave pend[i] unchanged, with no overflow.
REQ-021 push[i] with pend[i] at maximum and no legal grant on i SHALL hold pend[i] at maximum and set ovf[i].
REQ-022 Any nonzero gnt that is not a legal grant SHALL set gnt_err and SHALL change no counter.
REQ-023 The FSM SHALL have states IDLE=0 (all pend zero), ACTIVE=1 (some pend nonzero, en=1) and HOLD=2 (some pend nonzero, en=0).
REQ-024 The FSM SHALL be re-evaluated every cycle from the next-state values of pend and en; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-025 Sticky flags SHALL clear only on reset.

Reset
REQ-026 Asserting reset_n low SHALL force, asynchronously: pend=0, req=0, en=0, ovf=0, gnt_err=0, gnt_cnt=0, state=IDLE, starve=0, watchdog counters=0.
REQ-027 Reset asserted mid-operation SHALL discard all pending work.
REQ-028 The first update after deassertion SHALL occur on the first rising edge with reset_n high.

Configuration
REQ-029 Macro PS4_REQ_STARVE_EN defined: each channel SHALL count consecutive cycles with req[i]=1, en=1 and no legal grant on i.
REQ-030 With PS4_REQ_STARVE_EN defined, the count SHALL clear on a legal grant on i or when en=0, and starve[i] SHALL set when the count reaches STARVE_LIM.
REQ-031 Macro PS4_REQ_STARVE_EN undefined: starve SHALL be constant 0 and no watchdog logic SHALL exist.

Structure
REQ-032 Package ps4_req_pkg SHALL hold the FSM state typedef (IDLE/ACTIVE/HOLD), the channel count 4 and the gnt_cnt width 16.
REQ-033 Sub-module ps4_req_chan SHALL implement one channel: pending counter, overflow flag and optional watchdog; it SHALL be instantiated 4 times.

Verification
REQ-034 Reset, then push=0101 for 1 cycle with enable=1 and gnt=0 -> pend ch0=1, ch2=1; req=0101; state=ACTIVE.
REQ-035 From REQ-034, gnt=0100 for 1 cycle, then gnt=0001 for 1 cycle -> req=0001 then 0000; gnt_cnt=2; state=IDLE.
REQ-036 push[3]=1 for 8 cycles with gnt=0 -> pend ch3=7 after 7 cycles; ovf=1000 after the 8th.
REQ-037 gnt=0011, or gnt=1000 while req[3]=0, or any grant while en=0 -> gnt_err=1; pend and gnt_cnt unchanged.
REQ-038 Set pend ch1=2, then enable=0 -> state=HOLD after 1 cycle; then enable=1 -> state=ACTIVE after 1 cycle.
REQ-039 With PS4_REQ_STARVE_EN: req[0] held with en=1 and gnt=1000 continually -> starve[0]=1 after 15 cycles. Without the macro: starve stays 0000.

Source files
------------

// File: rtl/ps4_req_pkg.sv
// Shared types and constants for the ps4_requester slice: channel count,
// grant-counter width, top FSM state type and a one-hot helper.
package ps4_req_pkg;

    localparam int NUM_CH = 4;
    localparam int GCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [NUM_CH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ps4_requester_if.sv
// Bus bundle between the requester and its environment: work strobes and
// selector handshake in, counters/flags/state out.
interface ps4_requester_if #(
    parameter int CNT_W = 3
);
    import ps4_req_pkg::*;

    logic [NUM_CH-1:0]       push;
    logic                    enable;
    logic [NUM_CH-1:0]       gnt;
    logic [NUM_CH-1:0]       req;
    logic                    en;
    logic [NUM_CH*CNT_W-1:0] pend;
    logic [NUM_CH-1:0]       ovf;
    logic                    gnt_err;
    logic [GCNT_W-1:0]       gnt_cnt;
    logic [1:0]              state;
    logic [NUM_CH-1:0]       starve;

    modport master (
        output push, enable, gnt,
        input  req, en, pend, ovf, gnt_err, gnt_cnt, state, starve
    );

    modport slave (
        input  push, enable, gnt,
        output req, en, pend, ovf, gnt_err, gnt_cnt, state, starve
    );

endinterface

// File: rtl/ps4_req_chan.sv
// One requester channel: saturating pending counter, sticky overflow and,
// when PS4_REQ_STARVE_EN is defined, a starvation watchdog.
module ps4_req_chan #(
    parameter int CNT_W      = 3,
    parameter int STARVE_LIM = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             grant,
    input  logic             hold,
    input  logic             en,
    output logic             req,
    output logic [CNT_W-1:0] pend,
    output logic             pend_nz_next,
    output logic             ovf,
    output logic             starve
);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [CNT_W-1:0] pend_reg, pend_next;
    logic             ovf_reg, ovf_next;

    // An illegal grant anywhere freezes every pending counter for that cycle.
    always_comb begin
        pend_next = pend_reg;
        ovf_next  = ovf_reg;
        if (!hold) begin
            if (grant && !push) begin
                pend_next = pend_reg - PEND_ONE;
            end else if (push && !grant) begin
                if (pend_reg == PEND_MAX) begin
                    ovf_next = 1'b1;
                end else begin
                    pend_next = pend_reg + PEND_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
        end
    end

    assign req          = (pend_reg != '0);
    assign pend         = pend_reg;
    assign pend_nz_next = (pend_next != '0);
    assign ovf          = ovf_reg;

`ifdef PS4_REQ_STARVE_EN
    localparam int             WD_W   = $clog2(STARVE_LIM + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(STARVE_LIM);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_reg, wd_next;
    logic            starve_reg, starve_next;

    // Counts consecutive waiting cycles; saturates at the limit.
    always_comb begin
        wd_next = '0;
        if (req && en && !grant) begin
            wd_next = (wd_reg == WD_LIM) ? wd_reg : wd_reg + WD_ONE;
        end
        starve_next = starve_reg | (wd_next == WD_LIM);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_reg     <= '0;
            starve_reg <= 1'b0;
        end else begin
            wd_reg     <= wd_next;
            starve_reg <= starve_next;
        end
    end

    assign starve = starve_reg;
`else
    logic unused_en;
    assign unused_en = en;
    assign starve    = 1'b0;
`endif

endmodule

// File: rtl/ps4_requester.sv
// Four-channel request generator for an external priority selector with grant
// legality checking and a three-state FSM. Optional watchdog: PS4_REQ_STARVE_EN.
module ps4_requester
    import ps4_req_pkg::*;
#(
    parameter int CNT_W      = 3,
    parameter int STARVE_LIM = 15
) (
    input  logic           clock,
    input  logic           reset_n,
    ps4_requester_if.slave bus
);
    logic                    en_reg;
    logic [GCNT_W-1:0]       gnt_cnt_reg;
    logic                    gnt_err_reg;
    state_t                  state_reg, state_next;

    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       starve;
    logic [NUM_CH-1:0]       pend_nz_next;
    logic [NUM_CH*CNT_W-1:0] pend;
    logic [NUM_CH-1:0]       grant_ok;
    logic                    legal_any;
    logic                    illegal;

    // Legal only if one-hot, aimed at a requesting channel, while en is high.
    assign legal_any = is_onehot(bus.gnt) && en_reg && ((bus.gnt & req) != '0);
    assign illegal   = (bus.gnt != '0) && !legal_any;
    assign grant_ok  = legal_any ? bus.gnt : '0;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            ps4_req_chan #(
                .CNT_W      (CNT_W),
                .STARVE_LIM (STARVE_LIM)
            ) u_chan (
                .clock        (clock),
                .reset_n      (reset_n),
                .push         (bus.push[gi]),
                .grant        (grant_ok[gi]),
                .hold         (illegal),
                .en           (en_reg),
                .req          (req[gi]),
                .pend         (pend[gi*CNT_W +: CNT_W]),
                .pend_nz_next (pend_nz_next[gi]),
                .ovf          (ovf[gi]),
                .starve       (starve[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_reg      <= 1'b0;
            gnt_cnt_reg <= '0;
            gnt_err_reg <= 1'b0;
        end else begin
            en_reg      <= bus.enable;
            gnt_cnt_reg <= gnt_cnt_reg + GCNT_W'(legal_any);
            gnt_err_reg <= gnt_err_reg | illegal;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // State follows next-cycle pend and en; the unused encoding falls to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE, ACTIVE, HOLD: begin
                if (pend_nz_next != '0) begin
                    state_next = bus.enable ? ACTIVE : HOLD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.state = state_reg;
    end

    assign bus.req     = req;
    assign bus.en      = en_reg;
    assign bus.pend    = pend;
    assign bus.ovf     = ovf;
    assign bus.gnt_err = gnt_err_reg;
    assign bus.gnt_cnt = gnt_cnt_reg;
    assign bus.starve  = starve;

endmodule

// File: tb/tb_ps4_requester.sv
// Scoreboard bench for ps4_requester: directed scenarios then random traffic
// against a behavioural channel model.
module tb_ps4_requester;
    import ps4_req_pkg::*;

    localparam int CNT_W      = 3;
    localparam int STARVE_LIM = 15;
    localparam int PMAX       = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    ps4_requester_if #(.CNT_W(CNT_W)) bus();

    ps4_requester #(
        .CNT_W      (CNT_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]         req;
        logic               en;
        logic [4*CNT_W-1:0] pend;
        logic [3:0]         ovf;
        logic               gnt_err;
        logic [15:0]        gnt_cnt;
        logic [1:0]         state;
        logic [3:0]         starve;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   txn    = 0;

    int m_pend[4];
    bit m_ovf[4];
    int m_wd[4];
    bit m_starve[4];
    bit m_err;
    bit m_en;
    int m_cnt;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_ovf[i] = 0; m_wd[i] = 0; m_starve[i] = 0;
        end
        m_err = 0; m_en = 0; m_cnt = 0;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        bit any;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            e.req[i]               = (m_pend[i] != 0);
            e.pend[i*CNT_W +: CNT_W] = m_pend[i][CNT_W-1:0];
            e.ovf[i]               = m_ovf[i];
            e.starve[i]            = m_starve[i];
            if (m_pend[i] != 0) any = 1;
        end
        e.en      = m_en;
        e.gnt_err = m_err;
        e.gnt_cnt = m_cnt[15:0];
        e.state   = !any ? 2'd0 : (m_en ? 2'd1 : 2'd2);
        return e;
    endfunction

    // Applies one clock of the rules to the model state.
    function automatic void model_step(logic [3:0] p, logic e, logic [3:0] g);
        logic [3:0] rq;
        bit legal, illegal, gi;
        for (int i = 0; i < 4; i++) rq[i] = (m_pend[i] != 0);
        legal   = ($countones(g) == 1) && m_en && ((g & rq) != 0);
        illegal = (g != 0) && !legal;
        for (int i = 0; i < 4; i++) begin
            gi = legal && g[i];
            if (!illegal) begin
                if (gi && !p[i]) m_pend[i]--;
                else if (p[i] && !gi) begin
                    if (m_pend[i] == PMAX) m_ovf[i] = 1;
                    else m_pend[i]++;
                end
            end
`ifdef PS4_REQ_STARVE_EN
            if (rq[i] && m_en && !gi) m_wd[i] = (m_wd[i] < STARVE_LIM) ? m_wd[i] + 1 : m_wd[i];
            else m_wd[i] = 0;
            if (m_wd[i] == STARVE_LIM) m_starve[i] = 1;
`endif
        end
        if (legal) m_cnt = (m_cnt + 1) % 65536;
        if (illegal) m_err = 1;
        m_en = e;
    endfunction

    function automatic void cmp_all(exp_t e, string where);
        chk({where, ".req"},     64'(bus.req),     64'(e.req));
        chk({where, ".en"},      64'(bus.en),      64'(e.en));
        chk({where, ".pend"},    64'(bus.pend),    64'(e.pend));
        chk({where, ".ovf"},     64'(bus.ovf),     64'(e.ovf));
        chk({where, ".gnt_err"}, 64'(bus.gnt_err), 64'(e.gnt_err));
        chk({where, ".gnt_cnt"}, 64'(bus.gnt_cnt), 64'(e.gnt_cnt));
        chk({where, ".state"},   64'(bus.state),   64'(e.state));
        chk({where, ".starve"},  64'(bus.starve),  64'(e.starve));
    endfunction

    task automatic cycle(logic [3:0] p, logic e, logic [3:0] g);
        @(negedge clock);
        bus.push = p; bus.enable = e; bus.gnt = g;
        model_step(p, e, g);
        sb.push_back(snapshot());
    endtask

    function automatic logic [3:0] pick_gnt(int legal_pct, int junk_pct);
        int r, n;
        int cand[4];
        r = $urandom_range(0, 99);
        n = 0;
        if (r < legal_pct) begin
            for (int i = 0; i < 4; i++) if (m_pend[i] != 0) begin cand[n] = i; n++; end
            if (n == 0) return 4'b0000;
            return 4'(1 << cand[$urandom_range(0, n - 1)]);
        end
        if (r < legal_pct + junk_pct) return 4'($urandom_range(1, 15));
        return 4'b0000;
    endfunction

    // Monitor: one scoreboard entry is due just after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d: req=%b en=%b pend=%h ovf=%b err=%b cnt=%0d state=%0d starve=%b",
                         txn, bus.req, bus.en, bus.pend, bus.ovf, bus.gnt_err,
                         bus.gnt_cnt, bus.state, bus.starve);
                cmp_all(e, "txn");
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        bus.push = '0; bus.enable = 1'b0; bus.gnt = '0;
        model_reset();
        #2;
        cmp_all(snapshot(), "reset");
        @(negedge clock);
        sb.push_back(snapshot());
        @(negedge clock);
        reset_n = 1'b1;

        // Two requests, then serve them one by one.
        cycle(4'b0101, 1'b1, 4'b0000);
        cycle(4'b0000, 1'b1, 4'b0100);
        cycle(4'b0000, 1'b1, 4'b0001);
        // Saturate channel 3, then drain it.
        repeat (8) cycle(4'b1000, 1'b1, 4'b0000);
        repeat (7) cycle(4'b0000, 1'b1, 4'b1000);
        // Illegal grants: not one-hot, non-requesting channel, en low.
        cycle(4'b0010, 1'b1, 4'b0000);
        cycle(4'b0000, 1'b1, 4'b0011);
        cycle(4'b0000, 1'b1, 4'b1000);
        cycle(4'b0000, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b0, 4'b0010);
        // HOLD and back to ACTIVE.
        cycle(4'b0010, 1'b1, 4'b0000);
        cycle(4'b0000, 1'b0, 4'b0000);
        cycle(4'b0000, 1'b1, 4'b0000);
        // Starve channel 0 behind a grant the selector keeps aiming elsewhere.
        cycle(4'b0001, 1'b1, 4'b0000);
        repeat (20) cycle(4'b0000, 1'b1, 4'b1000);

        // Asynchronous reset in the middle of a cycle discards everything.
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        bus.push = '0; bus.enable = 1'b0; bus.gnt = '0;
        model_reset();
        #1;
        cmp_all(snapshot(), "midreset");
        @(negedge clock);
        sb.push_back(snapshot());
        @(negedge clock);
        reset_n = 1'b1;

        repeat (150) cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 90), pick_gnt(30, 10));
        repeat (250) cycle(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                           ($urandom_range(0, 99) < 80), pick_gnt(60, 10));

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clock);
        #2;
        chk("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
